// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and a multi-cycle instruction memory (slave).
interface fetch_stage_if;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemDone;
  logic [15:0] imemData;

  modport master (output imemReq, output imemAddr, input imemDone, input imemData);
  modport slave  (input imemReq, input imemAddr, output imemDone, output imemData);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a multi-cycle imem and holds
// the fetched instruction for IF/ID. Optional HALT handling under FETCH_HALT_EN.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 writeIfId,
  input  logic                 redirectEn,
  input  logic [15:0]          redirectPc,
  fetch_stage_if.master        imem,
  output logic [15:0]          pcOut,
  output logic [15:0]          instrOut,
  output logic                 validInsOut,
  output logic                 haltOut
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, HALTED} state_t;

  localparam logic [15:0] PC_INIT = RESET_PC & 16'hFFFE;

  state_t      r_state, w_state;
  logic [15:0] r_pc, w_pc;
  logic [15:0] r_reqAddr, w_reqAddr;
  logic [15:0] r_instrHold, w_instrHold;
  logic        r_discard, w_discard;

  logic [15:0] w_tgt, w_pcInc;
  logic        w_isHalt;

  assign w_tgt   = redirectPc & 16'hFFFE;
  assign w_pcInc = r_pc + 16'd2;

`ifdef FETCH_HALT_EN
  assign w_isHalt = (r_instrHold[15:11] == 5'b00000);
  assign haltOut  = (r_state == HALTED);
`else
  assign w_isHalt = 1'b0;
  assign haltOut  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= PC_INIT;
      r_reqAddr   <= PC_INIT;
      r_instrHold <= 16'h0000;
      r_discard   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_reqAddr   <= w_reqAddr;
      r_instrHold <= w_instrHold;
      r_discard   <= w_discard;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_reqAddr   = r_reqAddr;
    w_instrHold = r_instrHold;
    w_discard   = r_discard;
    case (r_state)
      IDLE: begin
        w_state   = REQ;
        w_reqAddr = r_pc;
      end
      REQ: begin
        if (redirectEn) begin
          w_pc = w_tgt;
          // An in-flight access cannot be cancelled; drop its data on arrival.
          if (imem.imemDone) begin
            w_reqAddr = w_tgt;
            w_discard = 1'b0;
          end else begin
            w_discard = 1'b1;
          end
        end else if (imem.imemDone) begin
          if (r_discard) begin
            w_discard = 1'b0;
            w_reqAddr = r_pc;
          end else begin
            w_instrHold = imem.imemData;
            w_state     = VALID;
          end
        end
      end
      VALID: begin
        if (redirectEn) begin
          w_pc      = w_tgt;
          w_reqAddr = w_tgt;
          w_state   = REQ;
        end else if (writeIfId) begin
          if (w_isHalt) begin
            w_state = HALTED;
          end else begin
            w_pc      = w_pcInc;
            w_reqAddr = w_pcInc;
            w_state   = REQ;
          end
        end
      end
      HALTED: begin
        if (redirectEn) begin
          w_pc      = w_tgt;
          w_reqAddr = w_tgt;
          w_state   = REQ;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign imem.imemReq  = (r_state == REQ);
  assign imem.imemAddr = r_reqAddr;
  assign pcOut         = w_pcInc;
  assign instrOut      = r_instrHold;
  // A redirect in the same cycle squashes the held instruction before IF/ID sees it.
  assign validInsOut   = (r_state == VALID) && !redirectEn;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable imem model;
// imem returns addr ^ 16'hC000, except 16'h0000 at address 16'h0300.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        writeIfId, redirectEn;
  logic [15:0] redirectPc;
  logic [15:0] pcOut, instrOut;
  logic        validInsOut, haltOut;

  int lat;
  int cnt;
  int checks = 0;
  int errors = 0;

  fetch_stage_if mb ();

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .writeIfId(writeIfId), .redirectEn(redirectEn),
    .redirectPc(redirectPc), .imem(mb.master), .pcOut(pcOut), .instrOut(instrOut),
    .validInsOut(validInsOut), .haltOut(haltOut)
  );

  always #5 clk = ~clk;

  // imem model: done asserted combinationally in the lat-th cycle of a request
  assign mb.imemDone = mb.imemReq && (cnt == lat - 1);
  assign mb.imemData = (mb.imemAddr == 16'h0300) ? 16'h0000 : (mb.imemAddr ^ 16'hC000);

  always @(posedge clk) begin
    if (!mb.imemReq || mb.imemDone) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    cnt = 0;
    lat = 1;
    rst = 1'b1;
    writeIfId = 1'b1;
    redirectEn = 1'b0;
    redirectPc = 16'h0000;
    #2;
    check("rst_req",   {15'd0, mb.imemReq}, 16'd0);
    check("rst_valid", {15'd0, validInsOut}, 16'd0);
    check("rst_halt",  {15'd0, haltOut}, 16'd0);
    check("rst_pcout", pcOut, 16'h0002);
    check("rst_instr", instrOut, 16'h0000);
    cyc; rst = 1'b0;

    // back-to-back fetch, 1-cycle memory
    cyc;
    check("f0_req",   {15'd0, mb.imemReq}, 16'd1);
    check("f0_addr",  mb.imemAddr, 16'h0000);
    check("f0_valid", {15'd0, validInsOut}, 16'd0);
    cyc;
    check("f0v_valid", {15'd0, validInsOut}, 16'd1);
    check("f0v_pcout", pcOut, 16'h0002);
    check("f0v_instr", instrOut, 16'hC000);
    cyc;
    check("f1_addr",  mb.imemAddr, 16'h0002);
    check("f1_valid", {15'd0, validInsOut}, 16'd0);
    cyc;
    check("f1v_valid", {15'd0, validInsOut}, 16'd1);
    check("f1v_pcout", pcOut, 16'h0004);
    check("f1v_instr", instrOut, 16'hC002);
    cyc;
    check("f2_addr", mb.imemAddr, 16'h0004);
    writeIfId = 1'b0;

    // stall in VALID for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc;
      check("stall_valid", {15'd0, validInsOut}, 16'd1);
      check("stall_pcout", pcOut, 16'h0006);
      check("stall_instr", instrOut, 16'hC004);
      check("stall_req",   {15'd0, mb.imemReq}, 16'd0);
    end
    writeIfId = 1'b1;
    cyc;
    check("f3_addr", mb.imemAddr, 16'h0006);
    lat = 4;

    // redirect in request cycle 2 of a 4-cycle access
    cyc;
    check("rd_c2_addr", mb.imemAddr, 16'h0006);
    redirectEn = 1'b1; redirectPc = 16'h0101;
    cyc;
    redirectEn = 1'b0;
    check("rd_c3_addr",  mb.imemAddr, 16'h0006);
    check("rd_c3_req",   {15'd0, mb.imemReq}, 16'd1);
    check("rd_c3_valid", {15'd0, validInsOut}, 16'd0);
    cyc;
    check("rd_c4_done",  {15'd0, mb.imemDone}, 16'd1);
    check("rd_c4_addr",  mb.imemAddr, 16'h0006);
    check("rd_c4_valid", {15'd0, validInsOut}, 16'd0);
    cyc;
    check("rd_new_addr",  mb.imemAddr, 16'h0100);
    check("rd_new_valid", {15'd0, validInsOut}, 16'd0);
    check("rd_new_pcout", pcOut, 16'h0102);
    lat = 1;
    cyc;
    check("rd_v_valid", {15'd0, validInsOut}, 16'd1);
    check("rd_v_instr", instrOut, 16'hC100);
    check("rd_v_pcout", pcOut, 16'h0102);

    // redirect with writeIfId in VALID: redirect wins, valid squashed
    redirectEn = 1'b1; redirectPc = 16'hFFFD;
    #1;
    check("sq_valid", {15'd0, validInsOut}, 16'd0);
    cyc;
    redirectEn = 1'b0;
    check("wr_addr",  mb.imemAddr, 16'hFFFC);
    check("wr_pcout", pcOut, 16'hFFFE);
    cyc;
    check("wr_v_pcout", pcOut, 16'hFFFE);
    cyc;
    check("wr_addr2", mb.imemAddr, 16'hFFFE);
    cyc;
    check("wrap_pcout", pcOut, 16'h0000);
    check("wrap_valid", {15'd0, validInsOut}, 16'd1);
    check("wrap_instr", instrOut, 16'h3FFE);
    cyc;
    check("wrap_addr", mb.imemAddr, 16'h0000);

    // redirect coincident with imemDone: data dropped, new request at once
    redirectEn = 1'b1; redirectPc = 16'h0200;
    cyc;
    redirectEn = 1'b0;
    check("rdd_addr",  mb.imemAddr, 16'h0200);
    check("rdd_valid", {15'd0, validInsOut}, 16'd0);
    check("rdd_pcout", pcOut, 16'h0202);
    cyc;
    check("rdd_v_instr", instrOut, 16'hC200);

    // fetch a HALT word
    redirectEn = 1'b1; redirectPc = 16'h0300;
    cyc;
    redirectEn = 1'b0;
    check("h_addr", mb.imemAddr, 16'h0300);
    cyc;
    check("h_valid", {15'd0, validInsOut}, 16'd1);
    check("h_instr", instrOut, 16'h0000);
    cyc;
`ifdef FETCH_HALT_EN
    check("h_halt",  {15'd0, haltOut}, 16'd1);
    check("h_req",   {15'd0, mb.imemReq}, 16'd0);
    check("h_hval",  {15'd0, validInsOut}, 16'd0);
    check("h_pcout", pcOut, 16'h0302);
    cyc;
    check("h_halt2", {15'd0, haltOut}, 16'd1);
    check("h_req2",  {15'd0, mb.imemReq}, 16'd0);
    redirectEn = 1'b1; redirectPc = 16'h0040;
    cyc;
    redirectEn = 1'b0;
    check("h_rd_req",  {15'd0, mb.imemReq}, 16'd1);
    check("h_rd_addr", mb.imemAddr, 16'h0040);
    check("h_rd_halt", {15'd0, haltOut}, 16'd0);
`else
    check("nh_halt", {15'd0, haltOut}, 16'd0);
    check("nh_req",  {15'd0, mb.imemReq}, 16'd1);
    check("nh_addr", mb.imemAddr, 16'h0302);
`endif

    // asynchronous reset in REQ
    rst = 1'b1;
    #1;
    check("ar_req",   {15'd0, mb.imemReq}, 16'd0);
    check("ar_pcout", pcOut, 16'h0002);
    check("ar_valid", {15'd0, validInsOut}, 16'd0);
    cyc; rst = 1'b0;
    cyc;
    check("ar_rel_req",  {15'd0, mb.imemReq}, 16'd1);
    check("ar_rel_addr", mb.imemAddr, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
